// File: rtl/hovalaag_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hovalaag_ctrl_pkg
// Shared types and constants for the Hovalaag run controller:
//   - DATA_W     : width of the core's IN/OUT data words
//   - run_state_t: controller states (IDLE, RESET, RUN, DONE)
//   - status_t   : end-of-run status codes reported on the status port
//   - sat_inc8   : saturating 8-bit increment used for the output counter
// ----------------------------------------------------------------------------
package hovalaag_ctrl_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_TIMEOUT   = 2'b01,
        ST_UNDERFLOW = 2'b10,
        ST_ABORT     = 2'b11
    } status_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hovalaag_in_fifo.sv
// ----------------------------------------------------------------------------
// hovalaag_in_fifo
// Small input-vector FIFO feeding one core input port.
//   clk, rst     : clock, synchronous active-high reset (flushes pointers)
//   wr_en/wr_data: push; dropped when full, even if a pop happens together
//   pop          : consume head; ignored when empty
//   head         : current head word straight from storage, 0 when empty
//   empty/full   : occupancy flags (full means count == DEPTH)
// ----------------------------------------------------------------------------
module hovalaag_in_fifo
    import hovalaag_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;
    logic          pop_ok;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // Fullness is judged before this cycle's pop, so a write at full is lost.
    assign wr_ok  = wr_en & ~full;
    assign pop_ok = pop & ~empty;

    // Head is read combinationally so the core sees it in the same cycle.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale words are hidden by the empty flag.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/hovalaag_run_ctrl.sv
// ----------------------------------------------------------------------------
// hovalaag_run_ctrl
// Run controller and I/O harness for the Hovalaag CPU core.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : begin a run (from IDLE/DONE) / terminate a run
//   out_target          : outputs expected for success (0 = no target)
//   cycle_limit         : maximum number of RUN cycles
//   inN_wr_*, inN_full  : input-vector FIFO write side for IN1/IN2
//   cpu_rst             : core reset, low only while in RUN
//   cpu_INN, cpu_INN_adv: FIFO heads to the core / core consumed a word
//   cpu_OUT*            : core output word, strobe and channel select
//   out_data/sel/valid  : accepted outputs, one cycle after acceptance
//   busy, done, status  : run progress and end reason
//   cycles, out_count   : RUN cycles and accepted outputs of current/last run
// ----------------------------------------------------------------------------
module hovalaag_run_ctrl
    import hovalaag_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CYC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        out_target,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic [DATA_W-1:0] in1_wr_data,
    input  logic              in1_wr_en,
    output logic              in1_full,
    input  logic [DATA_W-1:0] in2_wr_data,
    input  logic              in2_wr_en,
    output logic              in2_full,
    output logic              cpu_rst,
    output logic [DATA_W-1:0] cpu_IN1,
    output logic [DATA_W-1:0] cpu_IN2,
    input  logic              cpu_IN1_adv,
    input  logic              cpu_IN2_adv,
    input  logic [DATA_W-1:0] cpu_OUT,
    input  logic              cpu_OUT_valid,
    input  logic              cpu_OUT_select,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [CYC_W-1:0]  cycles,
    output logic [7:0]        out_count
);

    // ------------------------------------------------------------------
    // Input FIFOs (index 0 = IN1, index 1 = IN2)
    // ------------------------------------------------------------------
    logic              fifo_wr_en   [2];
    logic [DATA_W-1:0] fifo_wr_data [2];
    logic              fifo_adv     [2];
    logic              fifo_pop     [2];
    logic [DATA_W-1:0] fifo_head    [2];
    logic              fifo_empty   [2];
    logic              fifo_full    [2];
    logic              in_run;

    run_state_t        state_q, state_d;
    status_t           status_q, status_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [7:0]        out_count_q, out_count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sel_q, out_sel_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign in_run = (state_q == S_RUN);

    assign fifo_wr_en[0]   = in1_wr_en;
    assign fifo_wr_en[1]   = in2_wr_en;
    assign fifo_wr_data[0] = in1_wr_data;
    assign fifo_wr_data[1] = in2_wr_data;
    assign fifo_adv[0]     = cpu_IN1_adv;
    assign fifo_adv[1]     = cpu_IN2_adv;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        // The core may only drain inputs while it is actually running.
        assign fifo_pop[gi] = in_run & fifo_adv[gi];

        hovalaag_in_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr_en[gi]),
            .wr_data (fifo_wr_data[gi]),
            .pop     (fifo_pop[gi]),
            .head    (fifo_head[gi]),
            .empty   (fifo_empty[gi]),
            .full    (fifo_full[gi])
        );
    end

    assign cpu_IN1  = fifo_head[0];
    assign cpu_IN2  = fifo_head[1];
    assign in1_full = fifo_full[0];
    assign in2_full = fifo_full[1];

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    logic             first_cycle;
    logic             accept;
    logic [8:0]       count_inc;
    logic             hit_target;
    logic             underflow;
    logic [CYC_W-1:0] cyc_inc;
    logic             timeout;

    always_comb begin
        // cycles is cleared in RESET, so zero in RUN marks the first cycle,
        // where cpu_OUT_valid still holds a value registered during reset.
        first_cycle = (cycles_q == '0);
        accept      = in_run & ~first_cycle & cpu_OUT_valid;
        count_inc   = {1'b0, out_count_q} + 9'd1;
        hit_target  = accept && (out_target != 8'd0) && (count_inc == {1'b0, out_target});
        underflow   = (cpu_IN1_adv & fifo_empty[0]) | (cpu_IN2_adv & fifo_empty[1]);
        cyc_inc     = cycles_q + CYC_W'(1);
        // A zero limit behaves as a limit of one cycle.
        timeout     = (cycle_limit == '0) || (cyc_inc == cycle_limit);

        state_d     = state_q;
        status_d    = status_q;
        cycles_d    = cycles_q;
        out_count_d = out_count_q;
        out_valid_d = accept;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;

        // Acceptance is independent of ending: an output on the final
        // cycle is still counted and forwarded.
        if (accept) begin
            out_data_d  = cpu_OUT;
            out_sel_d   = cpu_OUT_select;
            out_count_d = sat_inc8(out_count_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                cycles_d    = '0;
                out_count_d = '0;
                status_d    = ST_OK;
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cycles_d = cyc_inc;
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (hit_target) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if (underflow) begin
                    state_d  = S_DONE;
                    status_d = ST_UNDERFLOW;
                end else if (timeout) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decoded flags are registered from the next state so they line up
        // with the state register itself.
        cpu_rst_d = (state_d != S_RUN);
        busy_d    = (state_d == S_RESET) || (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            cycles_q    <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign cycles    = cycles_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hovalaag_run_ctrl
// The bench plays the role of the core: each run follows a per-cycle script
// (adv, output strobes, FIFO writes, abort). A run-level model walks the same
// script against queue-based FIFOs to predict end cycle, status, counters and
// the forwarded output stream; expected outputs go into a scoreboard queue
// that an independent monitor drains whenever out_valid is seen.
// ----------------------------------------------------------------------------
module tb_hovalaag_run_ctrl;

    localparam int DEPTH = 8;
    localparam int CYC_W = 16;
    localparam int SLEN  = 64;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [7:0]       out_target;
    logic [CYC_W-1:0] cycle_limit;
    logic [11:0]      in1_wr_data, in2_wr_data;
    logic             in1_wr_en, in2_wr_en;
    logic             in1_full, in2_full;
    logic             cpu_rst;
    logic [11:0]      cpu_IN1, cpu_IN2;
    logic             cpu_IN1_adv, cpu_IN2_adv;
    logic [11:0]      cpu_OUT;
    logic             cpu_OUT_valid, cpu_OUT_select;
    logic [11:0]      out_data;
    logic             out_sel, out_valid, busy, done;
    logic [1:0]       status;
    logic [CYC_W-1:0] cycles;
    logic [7:0]       out_count;

    hovalaag_run_ctrl #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .out_target(out_target), .cycle_limit(cycle_limit),
        .in1_wr_data(in1_wr_data), .in1_wr_en(in1_wr_en), .in1_full(in1_full),
        .in2_wr_data(in2_wr_data), .in2_wr_en(in2_wr_en), .in2_full(in2_full),
        .cpu_rst(cpu_rst), .cpu_IN1(cpu_IN1), .cpu_IN2(cpu_IN2),
        .cpu_IN1_adv(cpu_IN1_adv), .cpu_IN2_adv(cpu_IN2_adv),
        .cpu_OUT(cpu_OUT), .cpu_OUT_valid(cpu_OUT_valid), .cpu_OUT_select(cpu_OUT_select),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .busy(busy), .done(done), .status(status), .cycles(cycles), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] m_q1 [$];
    logic [11:0] m_q2 [$];
    logic [12:0] exp_q [$];

    bit          s_a1 [SLEN], s_a2 [SLEN], s_ov [SLEN], s_sel [SLEN], s_w1 [SLEN], s_w2 [SLEN];
    logic [11:0] s_od [SLEN], s_wd1 [SLEN], s_wd2 [SLEN];
    int          s_abort_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] head_of(input int ch);
        if (ch == 1) return (m_q1.size() > 0) ? m_q1[0] : 12'd0;
        return (m_q2.size() > 0) ? m_q2[0] : 12'd0;
    endfunction

    // Scoreboard monitor: independent of stimulus timing.
    always @(negedge clk) begin
        logic [12:0] e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[11:0]));
                check("out_sel", 32'(out_sel), 32'(e[12]));
                $display("out: data=0x%03h sel=%0d count=%0d", out_data, out_sel, out_count);
            end
        end
    end

    task automatic clear_script();
        for (int k = 0; k < SLEN; k++) begin
            s_a1[k] = 0; s_a2[k] = 0; s_ov[k] = 0; s_sel[k] = 0; s_w1[k] = 0; s_w2[k] = 0;
            s_od[k] = '0; s_wd1[k] = '0; s_wd2[k] = '0;
        end
        s_abort_k = -1;
    endtask

    task automatic idle_inputs();
        cpu_IN1_adv = 0; cpu_IN2_adv = 0; cpu_OUT_valid = 0; cpu_OUT_select = 0; cpu_OUT = '0;
        in1_wr_en = 0; in2_wr_en = 0; abort = 0; start = 0;
    endtask

    task automatic fifo_write(input int ch, input logic [11:0] val);
        @(negedge clk);
        if (ch == 1) begin
            check("in1_full_idle", 32'(in1_full), 32'(m_q1.size() == DEPTH));
            check("in1_head_idle", 32'(cpu_IN1), 32'(head_of(1)));
            in1_wr_en = 1; in1_wr_data = val;
            if (m_q1.size() < DEPTH) m_q1.push_back(val);
        end else begin
            check("in2_full_idle", 32'(in2_full), 32'(m_q2.size() == DEPTH));
            check("in2_head_idle", 32'(cpu_IN2), 32'(head_of(2)));
            in2_wr_en = 1; in2_wr_data = val;
            if (m_q2.size() < DEPTH) m_q2.push_back(val);
        end
        @(posedge clk);
        #1;
        in1_wr_en = 0; in2_wr_en = 0;
    endtask

    task automatic do_run(input int target, input int limit, input bit abort_in_reset, input bit ov_in_reset);
        int  k, cnt, st;
        bit  ended, acc, und, hit, f1, f2;
        k = 0; cnt = 0; st = 0; ended = 0;
        @(negedge clk);
        out_target  = 8'(target);
        cycle_limit = CYC_W'(limit);
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_reset", 32'(busy), 32'd1);
        check("cpu_rst_reset", 32'(cpu_rst), 32'd1);
        abort = abort_in_reset;
        cpu_OUT_valid = ov_in_reset;
        cpu_OUT = 12'hEEE;
        if (abort_in_reset) begin
            st = 3;
            ended = 1;
        end
        while (!ended) begin
            @(negedge clk);
            check("cycles_run", 32'(cycles), 32'(k));
            check("cpu_rst_run", 32'(cpu_rst), 32'd0);
            check("in1_head", 32'(cpu_IN1), 32'(head_of(1)));
            check("in2_head", 32'(cpu_IN2), 32'(head_of(2)));
            check("in1_full", 32'(in1_full), 32'(m_q1.size() == DEPTH));
            check("in2_full", 32'(in2_full), 32'(m_q2.size() == DEPTH));
            cpu_IN1_adv = s_a1[k]; cpu_IN2_adv = s_a2[k];
            cpu_OUT_valid = s_ov[k]; cpu_OUT = s_od[k]; cpu_OUT_select = s_sel[k];
            in1_wr_en = s_w1[k]; in1_wr_data = s_wd1[k];
            in2_wr_en = s_w2[k]; in2_wr_data = s_wd2[k];
            abort = (k == s_abort_k);
            // Reference behaviour for this RUN cycle.
            acc = (k > 0) && s_ov[k];
            und = (s_a1[k] && m_q1.size() == 0) || (s_a2[k] && m_q2.size() == 0);
            f1 = (m_q1.size() == DEPTH);
            f2 = (m_q2.size() == DEPTH);
            if (s_a1[k] && m_q1.size() > 0) void'(m_q1.pop_front());
            if (s_a2[k] && m_q2.size() > 0) void'(m_q2.pop_front());
            if (s_w1[k] && !f1) m_q1.push_back(s_wd1[k]);
            if (s_w2[k] && !f2) m_q2.push_back(s_wd2[k]);
            hit = 0;
            if (acc) begin
                hit = (target != 0) && (cnt + 1 == target);
                if (cnt < 255) cnt++;
                exp_q.push_back({s_sel[k], s_od[k]});
            end
            ended = 1;
            if (k == s_abort_k)                 st = 3;
            else if (hit)                       st = 0;
            else if (und)                       st = 2;
            else if (limit == 0 || k + 1 == limit) st = 1;
            else                                ended = 0;
            k++;
            if (k >= SLEN) begin
                $display("FAIL run_length: model ran past %0d cycles", SLEN);
                $fatal(1, "run model overflow");
            end
        end
        @(negedge clk);
        idle_inputs();
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("cpu_rst_done", 32'(cpu_rst), 32'd1);
        check("status", 32'(status), 32'(st));
        check("cycles_final", 32'(cycles), 32'(k));
        check("out_count", 32'(out_count), 32'(cnt));
        $display("run: target=%0d limit=%0d -> status=%0d cycles=%0d out_count=%0d", target, limit, status, cycles, out_count);
        abort = 1;   // must be ignored in DONE
        @(negedge clk);
        abort = 0;
        check("done_hold", 32'(done), 32'd1);
        check("status_hold", 32'(status), 32'(st));
        check("outputs_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim, tgt, n;
        rst = 1;
        idle_inputs();
        out_target = '0; cycle_limit = '0; in1_wr_data = '0; in2_wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in1_full", 32'(in1_full), 32'd0);
        check("rst_in2_full", 32'(in2_full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in1_head", 32'(cpu_IN1), 32'd0);
        rst = 0;

        // Echo program: IN1 = 3,5 -> two outputs on OUT1, target reached.
        fifo_write(1, 12'd3);
        fifo_write(1, 12'd5);
        clear_script();
        s_a1[1] = 1; s_ov[1] = 1; s_od[1] = 12'd3;
        s_a1[2] = 1; s_ov[2] = 1; s_od[2] = 12'd5;
        do_run(2, 100, 0, 0);

        // Same program with IN1 empty: underflow.
        clear_script();
        s_a1[1] = 1;
        do_run(2, 100, 0, 0);

        // Silent program: timeout after exactly 10 RUN cycles.
        clear_script();
        do_run(0, 10, 0, 0);

        // Limit 0 ends after one cycle.
        clear_script();
        do_run(0, 0, 0, 0);

        // Stale strobe during reset and first RUN cycle is not accepted.
        clear_script();
        s_ov[0] = 1; s_od[0] = 12'h111;
        s_ov[2] = 1; s_od[2] = 12'h222; s_sel[2] = 1;
        do_run(0, 4, 0, 1);

        // Fill IN2, 9th write dropped; then write+pop at count 4.
        for (int i = 0; i < DEPTH; i++) fifo_write(2, 12'(12'h100 + i));
        fifo_write(2, 12'd7);
        @(negedge clk);
        check("in2_full_after_fill", 32'(in2_full), 32'd1);
        clear_script();
        for (int k = 0; k < 9; k++) s_a2[k] = 1;
        s_w2[4] = 1; s_wd2[4] = 12'hABC;
        do_run(0, 11, 0, 0);

        // Abort on RUN cycle 3 while the target output lands the same cycle.
        clear_script();
        s_ov[3] = 1; s_od[3] = 12'h3C3; s_abort_k = 3;
        do_run(1, 20, 0, 0);

        // Abort during RESET goes straight to DONE.
        clear_script();
        do_run(1, 20, 1, 1);

        // Reset in the middle of a run.
        fifo_write(1, 12'h0AA);
        @(negedge clk);
        out_target = 8'd0; cycle_limit = CYC_W'(50); start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        check("midrst_running", 32'(cpu_rst), 32'd0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_in1_head", 32'(cpu_IN1), 32'd0);
        check("midrst_cycles", 32'(cycles), 32'd0);
        rst = 0;
        m_q1.delete(); m_q2.delete(); exp_q.delete();

        // Randomised runs against the model.
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) fifo_write(1, 12'($urandom));
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) fifo_write(2, 12'($urandom));
            lim = $urandom_range(0, 40);
            tgt = $urandom_range(0, 4);
            clear_script();
            for (int k = 0; k < SLEN; k++) begin
                s_a1[k]  = ($urandom_range(0, 3) == 0);
                s_a2[k]  = ($urandom_range(0, 4) == 0);
                s_ov[k]  = ($urandom_range(0, 2) == 0);
                s_sel[k] = 1'($urandom);
                s_od[k]  = 12'($urandom);
                s_w1[k]  = ($urandom_range(0, 3) == 0);
                s_wd1[k] = 12'($urandom);
                s_w2[k]  = ($urandom_range(0, 3) == 0);
                s_wd2[k] = 12'($urandom);
            end
            if ($urandom_range(0, 5) == 0) s_abort_k = $urandom_range(0, lim);
            do_run(tgt, lim, ($urandom_range(0, 14) == 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
